fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 7 +
 rtl/fetch_skid_buffer.sv | 36 +++
 rtl/fetch_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: fetch FSM states, reset/bubble defaults and PC step shared by the fetch stage
package fetch_stage_pkg;
    typedef enum logic [1:0] {S_REQ, S_HOLD, S_FLUSH} fetch_state_t;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_1000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
    localparam int          PC_INC        = 4;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: single-entry {instruction, pc, full} holding register for words fetched under stall
module fetch_skid_buffer #(
    parameter int ADDRESS_SIZE = 32,
    parameter int INSTR_SIZE   = 32
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic                    i_unload,
    input  logic                    i_clear,
    input  logic [INSTR_SIZE-1:0]   i_instr,
    input  logic [ADDRESS_SIZE-1:0] i_pc,
    output logic [INSTR_SIZE-1:0]   o_instr,
    output logic [ADDRESS_SIZE-1:0] o_pc,
    output logic                    o_full
);
    logic [INSTR_SIZE-1:0]   r_instr;
    logic [ADDRESS_SIZE-1:0] r_pc;
    logic                    r_full;
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_full  <= 1'b0;
        end else begin
            r_full <= (i_clear || i_unload) ? 1'b0 : (i_load ? 1'b1 : r_full);
            if (i_load && !i_clear) begin
                r_instr <= i_instr;
                r_pc    <= i_pc;
            end
        end
    end
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_full  = r_full;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencer and instruction-memory requester feeding a registered fetch-to-decode stage
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                      ADDRESS_SIZE = 32,
    parameter int                      INSTR_SIZE   = 32,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = DEF_RESET_PC,
    parameter logic [INSTR_SIZE-1:0]   NOP_INSTR    = DEF_NOP_INSTR
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    IM_req,
    output logic [ADDRESS_SIZE-1:0] IM_addr,
    input  logic                    IM_ready,
    input  logic [INSTR_SIZE-1:0]   IM_data,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc,
    input  logic                    stall,
    output logic [INSTR_SIZE-1:0]   F_instruction,
    output logic [ADDRESS_SIZE-1:0] F_pc,
    output logic                    F_valid
);
    fetch_state_t            r_state, w_state_n;
    logic [ADDRESS_SIZE-1:0] r_pc, w_pc_n, r_fpc, w_fpc_n;
    logic [INSTR_SIZE-1:0]   r_finstr, w_finstr_n;
    logic                    r_fvalid, w_fvalid_n;
    logic                    w_load, w_unload, w_clear;
    logic [INSTR_SIZE-1:0]   w_buf_instr;
    logic [ADDRESS_SIZE-1:0] w_buf_pc;
    logic                    w_buf_full;
    fetch_skid_buffer #(.ADDRESS_SIZE(ADDRESS_SIZE), .INSTR_SIZE(INSTR_SIZE)) u_skid (
        .clk      (clk),
        .i_rst    (reset),
        .i_load   (w_load),
        .i_unload (w_unload),
        .i_clear  (w_clear),
        .i_instr  (IM_data),
        .i_pc     (r_pc),
        .o_instr  (w_buf_instr),
        .o_pc     (w_buf_pc),
        .o_full   (w_buf_full)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_finstr <= NOP_INSTR;
            r_fpc    <= '0;
            r_fvalid <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_pc     <= w_pc_n;
            r_finstr <= w_finstr_n;
            r_fpc    <= w_fpc_n;
            r_fvalid <= w_fvalid_n;
        end
    end
    always_comb begin
        w_state_n  = r_state;
        w_pc_n     = r_pc;
        w_finstr_n = r_finstr;
        w_fpc_n    = r_fpc;
        w_fvalid_n = r_fvalid;
        w_load     = 1'b0;
        w_unload   = 1'b0;
        w_clear    = 1'b0;
        if (redirect_valid) begin
            w_state_n  = S_FLUSH;
            w_pc_n     = redirect_pc;
            w_finstr_n = NOP_INSTR;
            w_fvalid_n = 1'b0;
            w_clear    = 1'b1;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (IM_ready) begin
                        w_pc_n = r_pc + ADDRESS_SIZE'(PC_INC);
                        if (stall) begin
                            w_load    = 1'b1;
                            w_state_n = S_HOLD;
                        end else begin
                            w_finstr_n = IM_data;
                            w_fpc_n    = r_pc;
                            w_fvalid_n = 1'b1;
                        end
                    end else if (!stall) begin
                        w_finstr_n = NOP_INSTR;
                        w_fvalid_n = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_finstr_n = w_buf_instr;
                        w_fpc_n    = w_buf_pc;
                        w_fvalid_n = w_buf_full;
                        w_unload   = 1'b1;
                        w_state_n  = S_REQ;
                    end
                end
                default: w_state_n = S_REQ;
            endcase
        end
    end
    // Gated by reset so no request is visible while reset is held
    assign IM_req        = (r_state == S_REQ) && !reset;
    assign IM_addr       = r_pc;
    assign F_instruction = r_finstr;
    assign F_pc          = r_fpc;
    assign F_valid       = r_fvalid;
endmodule
